if_fetch_queue: RTL

Instruction-fetch stage that sits directly downstream of the PC register. It takes the registered program counter, issues one instruction-memory request at a time, and buffers returned words with their PC in a small FIFO for decode. It drives a hold signal back to the PC mux so the PC advances only when a fetch is accepted, and discards stale responses on branch/jump redirects.

---
 rtl/if_fetch_queue_if.sv | 32 +++
 rtl/if_fetch_queue.sv | 80 ++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: bundles the PC, instruction-memory and decode-side signals of the fetch stage
// Ports (names follow the block's external pin names):
//   pc_in, pc_hold_out, flush_in          - PC register / redirect side
//   imem_req_out, imem_addr_out,
//   imem_gnt_in, imem_rvalid_in,
//   imem_rdata_in                         - instruction-memory request/response
//   id_valid_out, id_ready_in,
//   id_instr_out, id_pc_out, id_fault_out - decode-side FIFO head
// slave is the fetch queue itself; master is the surrounding pipeline/memory.
interface if_fetch_queue_if;
  logic [31:0] pc_in;
  logic        pc_hold_out;
  logic        flush_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        id_valid_out;
  logic        id_ready_in;
  logic [31:0] id_instr_out;
  logic [31:0] id_pc_out;
  logic        id_fault_out;
  modport slave (
    input  pc_in, flush_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in, id_ready_in,
    output pc_hold_out, imem_req_out, imem_addr_out, id_valid_out, id_instr_out, id_pc_out, id_fault_out
  );
  modport master (
    output pc_in, flush_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in, id_ready_in,
    input  pc_hold_out, imem_req_out, imem_addr_out, id_valid_out, id_instr_out, id_pc_out, id_fault_out
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetches one instruction at a time from pc_in and queues {pc, instr, fault} for decode
// Ports:
//   mp_clk_in - clock, rising edge
//   mp_rst_in - synchronous active-low reset
//   bus       - if_fetch_queue_if.slave carrying PC, imem and decode signals
module if_fetch_queue #(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic             mp_clk_in,
  input logic             mp_rst_in,
  if_fetch_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, FAULT} state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;
  state_e      state_q;
  entry_t      mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0] count_q, count_d;
  logic [31:0] req_pc_q;
  logic        aligned, push, pop, empty;
  entry_t      push_e, head;
  always_comb begin
    aligned = bus.pc_in[1:0] == 2'b00;
    empty   = count_q == '0;
    push    = !bus.flush_in && ((state_q == REQ && !aligned) || (state_q == WAIT && bus.imem_rvalid_in));
    pop     = !empty && bus.id_ready_in;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    // A push from REQ is always a misaligned-PC fault entry; from WAIT it is the returned word.
    push_e  = state_q == WAIT ? '{req_pc_q, bus.imem_rdata_in, 1'b0} : '{bus.pc_in, NOP_INSTR, 1'b1};
    head    = mem_q[rd_ptr_q];
  end
  assign bus.imem_req_out  = state_q == REQ && aligned;
  assign bus.imem_addr_out = bus.imem_req_out ? bus.pc_in : '0;
  assign bus.pc_hold_out   = !(bus.imem_req_out && bus.imem_gnt_in);
  assign bus.id_valid_out  = !empty;
  assign bus.id_instr_out  = empty ? NOP_INSTR : head.instr;
  assign bus.id_pc_out     = empty ? '0 : head.pc;
  assign bus.id_fault_out  = !empty && head.fault;
  always_ff @(posedge mp_clk_in) begin
    if (!mp_rst_in) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_pc_q <= '0;
    end else if (bus.flush_in) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      // A response still owed by memory must be swallowed before fetching again.
      state_q  <= ((state_q == WAIT && !bus.imem_rvalid_in) || (bus.imem_req_out && bus.imem_gnt_in)
                   || state_q == DROP) ? DROP : IDLE;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_e;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case (state_q)
        IDLE:    if (count_q < CNT_DEPTH) state_q <= REQ;
        REQ:     if (!aligned) state_q <= FAULT;
                 else if (bus.imem_gnt_in) begin
                   req_pc_q <= bus.pc_in;
                   state_q  <= WAIT;
                 end
        WAIT:    if (bus.imem_rvalid_in) state_q <= count_d < CNT_DEPTH ? REQ : IDLE;
        DROP:    if (bus.imem_rvalid_in) state_q <= IDLE;
        default: ;
      endcase
    end
  end
endmodule
